mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port unified program/data memory between two requesters. Requester A is the CPU ControlMatrix, for fetch and load/store. Requester B is the debug/loader port, used to preload and inspect memory.
- Fixed priority to A, with a starvation guard so B always progresses.
- Sits between the requesters and the memory; the memory has a synchronous read with 1-cycle latency.

Parameters:
- DataWidth, 16: memory word width.
- AddrWidth, 8: memory address width.
- StarveLimit, 4: consecutive lost arbitrations after which B is forced to win (range 1..15).

Ports:
- Clk, input, 1: system clock; all state updates on posedge.
- Reset, input, 1: asynchronous, active-low reset.
- A_Req, input, 1: CPU request; held until A_Done.
- A_Wr, input, 1: 1 = write, 0 = read.
- A_Addr, input, AddrWidth: CPU address.
- A_WData, input, DataWidth: CPU write data.
- A_Gnt, output, 1: high while A owns the memory.
- A_Done, output, 1: one-cycle completion pulse to A.
- A_RData, output, DataWidth: read data for A; valid while A_Done is high, held until A's next read completes.
- B_Req, B_Wr, B_Addr, B_WData, B_Gnt, B_Done, B_RData: same as the A ports, for the debug/loader requester.
- Mem_Addr, output, AddrWidth: memory address.
- Mem_WData, output, DataWidth: memory write data.
- Mem_Wr, output, 1: memory write enable.
- Mem_RData, input, DataWidth: memory read data, one cycle after the address.
- Busy, output, 1: high in any state other than S_Idle.

Behaviour:
- Reset (Reset=0, asynchronous): state := S_Idle. All outputs are 0: Gnt, Done, RData, Mem_Addr, Mem_WData, Mem_Wr, Busy. Starvation counter := 0.
- FSM states: S_Idle, S_Access, S_Complete. Every transaction takes exactly 3 cycles, from the S_Idle sample edge to the end of the Done cycle.
- S_Idle:
  - Sample A_Req and B_Req. If neither is set, stay in S_Idle.
  - Winner is B if B_Req and (no A_Req, or starve_cnt == StarveLimit); otherwise A.
  - On a winner: latch that requester's Wr, Addr and WData into internal registers, assert its Gnt, go to S_Access.
- S_Access:
  - Mem_Addr and Mem_WData come from the latched registers. Mem_Wr = latched Wr, high for exactly this one cycle.
  - Next state is S_Complete.
- S_Complete:
  - For a read, capture Mem_RData into the winner's RData.
  - Pulse the winner's Done for this one cycle. Mem_Wr = 0.
  - On exit, deassert Gnt and go to S_Idle.
- Gnt is high in S_Access and S_Complete only. At most one Gnt is high at any time, and at most one Done.
- Handshake:
  - The requester holds Req and its request fields stable until Done.
  - Once the winner is latched, the transaction is committed. Dropping Req or changing Addr/WData afterwards has no effect on the access in flight.
  - If Req is still high in S_Idle after Done, it is treated as a new request.
- Starvation counter (4 bits, saturating at StarveLimit):
  - Increments in S_Idle when B_Req=1 and A wins.
  - Clears when B wins, or in S_Idle when B_Req=0.
- Writes: RData is unchanged on a write. Done pulses for writes and reads alike.
- Reset mid-transaction: immediate return to S_Idle. Mem_Wr drops asynchronously. No Done pulse is issued and the counter is cleared. Requesters must re-issue.
- Simultaneous requests with starve_cnt < StarveLimit: A wins and B waits with Req held.

Test Plan:
- A read, Addr=0x05, memory[5]=0x1234 -> A_Gnt high 2 cycles; Mem_Addr=0x05 in S_Access; A_Done pulses 3rd cycle with A_RData=0x1234; B outputs stay 0.
- B write, Addr=0x0A, WData=0xBEEF -> Mem_Wr high exactly 1 cycle with Mem_Addr=0x0A and Mem_WData=0xBEEF; B_Done pulses; B_RData unchanged; memory[0x0A] reads back 0xBEEF.
- A_Req and B_Req rise on the same cycle -> A served first; B served immediately after A_Done; each Done seen once; Gnt never overlaps.
- A_Req held continuously with B_Req held, StarveLimit=4 -> exactly 4 A transactions, then 1 B transaction, then A resumes.
- Reset pulled low during S_Access of an A write to 0x03 -> Mem_Wr falls immediately; no A_Done; memory[3] keeps its old value when reset lands before the write edge; FSM in S_Idle and Busy=0 after release.
- Req dropped during S_Access -> transaction still completes with a Done pulse; S_Idle then sees no request and stays idle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for a single-port unified memory shared by the CPU (A) and the debug/loader port (B).
// A has fixed priority; a saturating starvation counter forces B to win after StarveLimit losses.
module mem_arbiter #(
    parameter int unsigned DataWidth   = 16,
    parameter int unsigned AddrWidth   = 8,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 A_Req,
    input  logic                 A_Wr,
    input  logic [AddrWidth-1:0] A_Addr,
    input  logic [DataWidth-1:0] A_WData,
    output logic                 A_Gnt,
    output logic                 A_Done,
    output logic [DataWidth-1:0] A_RData,
    input  logic                 B_Req,
    input  logic                 B_Wr,
    input  logic [AddrWidth-1:0] B_Addr,
    input  logic [DataWidth-1:0] B_WData,
    output logic                 B_Gnt,
    output logic                 B_Done,
    output logic [DataWidth-1:0] B_RData,
    output logic [AddrWidth-1:0] Mem_Addr,
    output logic [DataWidth-1:0] Mem_WData,
    output logic                 Mem_Wr,
    input  logic [DataWidth-1:0] Mem_RData,
    output logic                 Busy
);

    localparam int unsigned CntWidth = 4;

    typedef enum logic [1:0] {
        S_Idle,
        S_Access,
        S_Complete
    } state_t;

    state_t                 state, state_n;
    logic                   win_b, win_b_n;
    logic                   wr_q, wr_n;
    logic [CntWidth-1:0]    starve_cnt, cnt_n;
    logic                   a_gnt_q, a_gnt_n, b_gnt_q, b_gnt_n;
    logic                   a_done_q, a_done_n, b_done_q, b_done_n;
    logic [DataWidth-1:0]   a_rdata_q, a_rdata_n, b_rdata_q, b_rdata_n;
    logic [AddrWidth-1:0]   mem_addr_q, mem_addr_n;
    logic [DataWidth-1:0]   mem_wdata_q, mem_wdata_n;
    logic                   mem_wr_q, mem_wr_n;
    logic                   busy_q, busy_n;
    logic                   pick_b;
    logic                   starve_hit;

    assign starve_hit = (starve_cnt == CntWidth'(StarveLimit));

    // State and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_Idle;
            win_b       <= 1'b0;
            wr_q        <= 1'b0;
            starve_cnt  <= '0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            win_b       <= win_b_n;
            wr_q        <= wr_n;
            starve_cnt  <= cnt_n;
            a_gnt_q     <= a_gnt_n;
            b_gnt_q     <= b_gnt_n;
            a_done_q    <= a_done_n;
            b_done_q    <= b_done_n;
            a_rdata_q   <= a_rdata_n;
            b_rdata_q   <= b_rdata_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            mem_wr_q    <= mem_wr_n;
            busy_q      <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        win_b_n     = win_b;
        wr_n        = wr_q;
        cnt_n       = starve_cnt;
        a_gnt_n     = a_gnt_q;
        b_gnt_n     = b_gnt_q;
        a_done_n    = 1'b0;
        b_done_n    = 1'b0;
        a_rdata_n   = a_rdata_q;
        b_rdata_n   = b_rdata_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        mem_wr_n    = 1'b0;
        busy_n      = busy_q;
        pick_b      = 1'b0;

        unique case (state)
            S_Idle: begin
                pick_b = B_Req && (!A_Req || starve_hit);
                // A can only beat a waiting B below the limit, so the increment saturates
                if (!B_Req || pick_b) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = starve_cnt + CntWidth'(1);
                end
                if (A_Req || B_Req) begin
                    state_n     = S_Access;
                    win_b_n     = pick_b;
                    wr_n        = pick_b ? B_Wr : A_Wr;
                    mem_addr_n  = pick_b ? B_Addr : A_Addr;
                    mem_wdata_n = pick_b ? B_WData : A_WData;
                    mem_wr_n    = wr_n;
                    a_gnt_n     = !pick_b;
                    b_gnt_n     = pick_b;
                    busy_n      = 1'b1;
                end
            end
            S_Access: begin
                state_n  = S_Complete;
                a_done_n = !win_b;
                b_done_n = win_b;
            end
            S_Complete: begin
                state_n = S_Idle;
                a_gnt_n = 1'b0;
                b_gnt_n = 1'b0;
                busy_n  = 1'b0;
                if (!wr_q) begin
                    if (win_b) begin
                        b_rdata_n = Mem_RData;
                    end else begin
                        a_rdata_n = Mem_RData;
                    end
                end
            end
            default: begin
                state_n = S_Idle;
            end
        endcase
    end

    // Read data arrives during the Done cycle, so it is forwarded then and held afterwards
    assign A_RData   = (state == S_Complete && !win_b && !wr_q) ? Mem_RData : a_rdata_q;
    assign B_RData   = (state == S_Complete &&  win_b && !wr_q) ? Mem_RData : b_rdata_q;
    assign A_Gnt     = a_gnt_q;
    assign B_Gnt     = b_gnt_q;
    assign A_Done    = a_done_q;
    assign B_Done    = b_done_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_WData = mem_wdata_q;
    assign Mem_Wr    = mem_wr_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model behind the arbiter and a scoreboard of
// expected completions (side and returned read data) in issue order.
module tb_mem_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned SL = 4;

    typedef struct packed {
        logic          is_b;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_wr, b_req, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_done, b_gnt, b_done;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wr, busy;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] mem_exp [256];
    logic [DW-1:0] last_rd [2];
    exp_t          exp_q[$];

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int overlap_err = 0;
    int wr_cycles = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    always #5 clk = ~clk;

    mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .StarveLimit(SL)) dut (
        .Clk(clk), .Reset(rst_n),
        .A_Req(a_req), .A_Wr(a_wr), .A_Addr(a_addr), .A_WData(a_wdata),
        .A_Gnt(a_gnt), .A_Done(a_done), .A_RData(a_rdata),
        .B_Req(b_req), .B_Wr(b_wr), .B_Addr(b_addr), .B_WData(b_wdata),
        .B_Gnt(b_gnt), .B_Done(b_done), .B_RData(b_rdata),
        .Mem_Addr(mem_addr), .Mem_WData(mem_wdata), .Mem_Wr(mem_wr),
        .Mem_RData(mem_rdata), .Busy(busy)
    );

    // Synchronous single-port memory, one-cycle read latency
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic score(input logic is_b, input logic [DW-1:0] rd);
        exp_t e;
        done_count++;
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(is_b ? "done_side_b" : "done_side_a", 32'(is_b), 32'(e.is_b));
            check(is_b ? "b_rdata" : "a_rdata", 32'(rd), 32'(e.rdata));
        end
    endtask

    // Completion monitor and exclusivity tracking
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_gnt && b_gnt) overlap_err++;
            if (a_done && b_done) overlap_err++;
            if (mem_wr) begin
                wr_cycles++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end
            if (a_done) score(1'b0, a_rdata);
            if (b_done) score(1'b1, b_rdata);
        end
    end

    task automatic push_exp(input logic is_b, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
        exp_t e;
        e.is_b = is_b;
        if (wr) begin
            mem_exp[addr] = wdata;
            e.rdata = last_rd[is_b];
        end else begin
            e.rdata = mem_exp[addr];
            last_rd[is_b] = e.rdata;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        a_req = req; a_wr = wr; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        b_req = req; b_wr = wr; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic wait_dones(input int target, input bit drop_a, input bit drop_b);
        for (int i = 0; i < 60 && done_count < target; i++) begin
            tick();
            if (drop_a && a_done) a_req = 1'b0;
            if (drop_b && b_done) b_req = 1'b0;
        end
        check("done_count", 32'(done_count), 32'(target));
    endtask

    task automatic run_txn(input logic is_b, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        int tgt;
        tgt = done_count + 1;
        if (is_b) drive_b(1'b1, wr, addr, wdata);
        else      drive_a(1'b1, wr, addr, wdata);
        push_exp(is_b, wr, addr, wdata);
        wait_dones(tgt, 1'b1, 1'b1);
        tick();
    endtask

    initial begin
        int wr0;
        int tgt;
        int d0;
        rst_n = 1'b0;
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        tick();
        tick();
        check("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        check("rst_done", 32'({a_done, b_done}), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_mem_wr_busy", 32'({mem_wr, busy}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Preload through the loader port
        run_txn(1'b1, 1'b1, 8'h05, 16'h1234);
        run_txn(1'b1, 1'b1, 8'h03, 16'h0303);

        // A read of 0x05, cycle by cycle
        drive_a(1'b1, 1'b0, 8'h05, 16'h0000);
        push_exp(1'b0, 1'b0, 8'h05, 16'h0000);
        tick();
        check("acc_a_gnt", 32'(a_gnt), 32'd1);
        check("acc_mem_addr", 32'(mem_addr), 32'h05);
        check("acc_mem_wr", 32'(mem_wr), 32'd0);
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_b_gnt", 32'(b_gnt), 32'd0);
        tick();
        check("cpl_a_done", 32'(a_done), 32'd1);
        check("cpl_a_gnt", 32'(a_gnt), 32'd1);
        check("cpl_a_rdata", 32'(a_rdata), 32'h1234);
        a_req = 1'b0;
        tick();
        check("idle_a_gnt", 32'(a_gnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_a_done", 32'(a_done), 32'd0);
        check("idle_a_rdata_held", 32'(a_rdata), 32'h1234);
        check("idle_b_quiet", 32'({b_gnt, b_done, b_rdata}), 32'd0);

        // B write 0xBEEF to 0x0A, then read it back
        wr0 = wr_cycles;
        run_txn(1'b1, 1'b1, 8'h0A, 16'hBEEF);
        check("bw_wr_cycles", 32'(wr_cycles - wr0), 32'd1);
        check("bw_wr_addr", 32'(last_wr_addr), 32'h0A);
        check("bw_wr_data", 32'(last_wr_data), 32'hBEEF);
        check("bw_b_rdata", 32'(b_rdata), 32'd0);
        check("bw_mem", 32'(mem[8'h0A]), 32'hBEEF);
        run_txn(1'b1, 1'b0, 8'h0A, 16'h0000);

        // Simultaneous: A write then B read of the same word
        tgt = done_count + 2;
        drive_a(1'b1, 1'b1, 8'h20, 16'h1111);
        drive_b(1'b1, 1'b0, 8'h20, 16'h0000);
        push_exp(1'b0, 1'b1, 8'h20, 16'h1111);
        push_exp(1'b1, 1'b0, 8'h20, 16'h0000);
        wait_dones(tgt, 1'b1, 1'b1);
        tick();
        check("sim_pending", 32'(exp_q.size()), 32'd0);
        check("sim_overlap", 32'(overlap_err), 32'd0);

        // Starvation guard: four A wins, one B, then A again
        tgt = done_count + 6;
        drive_a(1'b1, 1'b0, 8'h05, 16'h0000);
        drive_b(1'b1, 1'b0, 8'h0A, 16'h0000);
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 8'h05, 16'h0000);
        push_exp(1'b1, 1'b0, 8'h0A, 16'h0000);
        push_exp(1'b0, 1'b0, 8'h05, 16'h0000);
        wait_dones(tgt, 1'b0, 1'b0);
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        tick();
        check("stv_busy", 32'(busy), 32'd0);
        check("stv_pending", 32'(exp_q.size()), 32'd0);

        // Reset during the access cycle of an A write
        d0 = done_count;
        drive_a(1'b1, 1'b1, 8'h03, 16'hDEAD);
        tick();
        check("rmid_mem_wr_before", 32'(mem_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_mem_wr_async", 32'(mem_wr), 32'd0);
        check("rmid_gnt_busy", 32'({a_gnt, busy}), 32'd0);
        a_req = 1'b0;
        tick();
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        tick();
        tick();
        check("rmid_busy_after", 32'(busy), 32'd0);
        check("rmid_no_done", 32'(done_count), 32'(d0));
        check("rmid_mem_kept", 32'(mem[8'h03]), 32'h0303);
        check("rmid_a_rdata", 32'(a_rdata), 32'd0);
        run_txn(1'b1, 1'b0, 8'h03, 16'h0000);

        // Request dropped and address changed during the access cycle
        tgt = done_count + 1;
        drive_a(1'b1, 1'b0, 8'h05, 16'h0000);
        push_exp(1'b0, 1'b0, 8'h05, 16'h0000);
        tick();
        a_req = 1'b0;
        a_addr = 8'h99;
        check("drop_mem_addr", 32'(mem_addr), 32'h05);
        wait_dones(tgt, 1'b1, 1'b1);
        tick();
        tick();
        check("drop_idle", 32'({busy, a_gnt}), 32'd0);
        check("drop_a_rdata", 32'(a_rdata), 32'h1234);

        check("final_pending", 32'(exp_q.size()), 32'd0);
        check("final_overlap", 32'(overlap_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
